sap3_ext_mem: RTL and testbench

External-memory responder for the SAP-3 core's off-chip memory interface.
- The core exports the 14-bit bus (low byte on uio_out, bits 13:8 on uio_oe[5:0]) and the strobes mem_mar_we (uio_oe[7]) and mem_ram_we (uio_oe[6]).
- The core reads memory back through ui_in.
- This block is the far end of that interface: it latches MAR, performs RAM writes, and returns read data.
- It contains a byte-serial program loader that holds the CPU while a program image is written.
- It instantiates in the FPGA/test harness next to the chip and in the top-level simulation.

---
 rtl/sap3_mem_pkg.sv | 10 +
 rtl/sap3_mem_loader.sv | 55 +++++
 rtl/sap3_ext_mem.sv | 59 +++++
 tb/tb_sap3_ext_mem.sv | 118 +++++++++++
 4 files changed

// File: rtl/sap3_mem_pkg.sv
// sap3_mem_pkg: shared types and constants for the SAP-3 external memory responder
package sap3_mem_pkg;
  localparam int DATA_W = 8;
  localparam int DEF_ADDR_W = 14;
  localparam int HDR_BYTES = 3;
  typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, HDR_LEN, DATA} ld_state_t;
  function automatic logic [8:0] len_dec(input logic [7:0] b);
    return b == 8'd0 ? 9'd256 : {1'b0, b};
  endfunction
endpackage

// File: rtl/sap3_mem_loader.sv
// sap3_mem_loader: byte-serial program loader; a 3-byte header {addr_hi, addr_lo, len}
// is followed by len data bytes, and the CPU is held for the whole session
module sap3_mem_loader
  import sap3_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic              cpu_hold,
  output logic              ld_we,
  output logic [ADDR_W-1:0] ld_waddr,
  output logic [7:0]        ld_wdata
);
  ld_state_t         r_state, w_next;
  logic [7:0]        r_hi;
  logic [ADDR_W-1:0] r_addr;
  logic [8:0]        r_cnt;
  logic              w_xfer;
  always_comb begin
    ld_ready = r_state != IDLE;
    cpu_hold = r_state != IDLE;
    w_xfer   = ld_valid && ld_ready;
    ld_we    = w_xfer && r_state == DATA;
    ld_waddr = r_addr;
    ld_wdata = ld_data;
    w_next   = r_state;
    unique case (r_state)
      IDLE:    w_next = ld_start ? HDR_HI : IDLE;
      HDR_HI:  w_next = w_xfer ? HDR_LO : HDR_HI;
      HDR_LO:  w_next = w_xfer ? HDR_LEN : HDR_LO;
      HDR_LEN: w_next = w_xfer ? DATA : HDR_LEN;
      DATA:    w_next = (w_xfer && r_cnt == 9'd1) ? IDLE : DATA;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  // header/count registers need no reset: they are always rewritten before use
  always_ff @(posedge clk) begin
    if (w_xfer && r_state == HDR_HI) r_hi <= ld_data;
    if (w_xfer && r_state == HDR_LO) r_addr <= ADDR_W'({r_hi, ld_data});
    if (w_xfer && r_state == HDR_LEN) r_cnt <= len_dec(ld_data);
    if (ld_we) begin
      r_addr <= r_addr + 1'b1;
      r_cnt  <= r_cnt - 9'd1;
    end
  end
endmodule

// File: rtl/sap3_ext_mem.sv
// sap3_ext_mem: far end of the SAP-3 off-chip memory bus; MAR, RAM, registered
// read-before-write data return, and a loader that holds the CPU while programming
module sap3_ext_mem
  import sap3_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] bus_in,
  input  logic              mar_we,
  input  logic              ram_we,
  output logic [DATA_W-1:0] mem_out,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] mar_q
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_out;
  logic              w_ld_we, w_we;
  logic [ADDR_W-1:0] w_ld_waddr, w_waddr;
  logic [7:0]        w_ld_wdata, w_wdata;
  sap3_mem_loader #(.ADDR_W(ADDR_W)) u_ld (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .cpu_hold (cpu_hold),
    .ld_we    (w_ld_we),
    .ld_waddr (w_ld_waddr),
    .ld_wdata (w_ld_wdata)
  );
  // CPU strobes are gated by cpu_hold, so the loader owns the write port exclusively
  always_comb begin
    w_we    = rst_n && (w_ld_we || (!cpu_hold && ram_we));
    w_waddr = w_ld_we ? w_ld_waddr : r_mar;
    w_wdata = w_ld_we ? w_ld_wdata : bus_in[7:0];
  end
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mar <= '0;
      r_out <= '0;
    end else begin
      r_out <= r_mem[r_mar];
      if (!cpu_hold && mar_we) r_mar <= bus_in;
    end
  end
  assign mem_out = r_out;
  assign mar_q   = r_mar;
endmodule

// File: tb/tb_sap3_ext_mem.sv
// tb_sap3_ext_mem: directed vector table plus hand sequences for wrap, 256-byte load
module tb_sap3_ext_mem;
  import sap3_mem_pkg::*;
  typedef struct packed {
    logic        r;
    logic [13:0] b;
    logic        mw, rw, st, v;
    logic [7:0]  d;
    logic [7:0]  eo;
    logic [13:0] em;
    logic        eh, ey, co;
  } vec_t;
  logic        clk = 1'b0, rst_n = 1'b0, mar_we = 1'b0, ram_we = 1'b0;
  logic        ld_start = 1'b0, ld_valid = 1'b0;
  logic [13:0] bus_in = '0;
  logic [7:0]  ld_data = '0;
  logic [7:0]  mem_out;
  logic        ld_ready, cpu_hold;
  logic [13:0] mar_q;
  int          pass = 0, total = 0;
  vec_t        q[$];
  sap3_ext_mem dut (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .mar_we(mar_we), .ram_we(ram_we),
    .mem_out(mem_out), .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .cpu_hold(cpu_hold), .mar_q(mar_q)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic r, input logic [13:0] b, input logic mw, rw, st, v,
                              input logic [7:0] d, eo, input logic [13:0] em,
                              input logic eh, ey, co);
    return '{r: r, b: b, mw: mw, rw: rw, st: st, v: v, d: d, eo: eo, em: em, eh: eh, ey: ey, co: co};
  endfunction
  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    total++;
    if (a !== e) $display("FAIL %s got %h want %h", n, a, e);
    else pass++;
  endtask
  task automatic step(input vec_t t, input string n);
    rst_n = t.r; bus_in = t.b; mar_we = t.mw; ram_we = t.rw;
    ld_start = t.st; ld_valid = t.v; ld_data = t.d;
    @(posedge clk);
    #1;
    chk({n, " mar"}, 16'(mar_q), 16'(t.em));
    chk({n, " hold"}, 16'(cpu_hold), 16'(t.eh));
    chk({n, " rdy"}, 16'(ld_ready), 16'(t.ey));
    if (t.co) chk({n, " out"}, 16'(mem_out), 16'(t.eo));
  endtask
  initial begin
    // reset with strobes toggling
    q.push_back(mk(0, 14'h1234, 1, 1, 0, 0, 8'h00, 8'h00, 14'h0000, 0, 0, 1));
    q.push_back(mk(0, 14'h0155, 1, 0, 0, 0, 8'h00, 8'h00, 14'h0000, 0, 0, 1));
    // load 3 bytes at 0x10 with a bubble; mar_we during bubble is gated
    q.push_back(mk(1, 14'h0000, 0, 0, 1, 0, 8'h00, 8'h00, 14'h0000, 1, 1, 0));
    q.push_back(mk(1, 14'h0000, 0, 0, 0, 1, 8'h00, 8'h00, 14'h0000, 1, 1, 0));
    q.push_back(mk(1, 14'h0000, 0, 0, 0, 1, 8'h10, 8'h00, 14'h0000, 1, 1, 0));
    q.push_back(mk(1, 14'h0000, 0, 0, 0, 1, 8'h03, 8'h00, 14'h0000, 1, 1, 0));
    q.push_back(mk(1, 14'h0000, 0, 0, 0, 1, 8'hAA, 8'h00, 14'h0000, 1, 1, 0));
    q.push_back(mk(1, 14'h3333, 1, 0, 0, 0, 8'h55, 8'h00, 14'h0000, 1, 1, 0));
    q.push_back(mk(1, 14'h0000, 0, 0, 0, 1, 8'hBB, 8'h00, 14'h0000, 1, 1, 0));
    q.push_back(mk(1, 14'h0000, 0, 0, 0, 1, 8'hCC, 8'h00, 14'h0000, 0, 0, 0));
    // CPU reads of loaded bytes
    q.push_back(mk(1, 14'h0011, 1, 0, 0, 0, 8'h00, 8'h00, 14'h0011, 0, 0, 0));
    q.push_back(mk(1, 14'h0000, 0, 0, 0, 0, 8'h00, 8'hBB, 14'h0011, 0, 0, 1));
    q.push_back(mk(1, 14'h0010, 1, 0, 0, 0, 8'h00, 8'hBB, 14'h0010, 0, 0, 1));
    q.push_back(mk(1, 14'h0012, 1, 0, 0, 0, 8'h00, 8'hAA, 14'h0012, 0, 0, 1));
    q.push_back(mk(1, 14'h0000, 0, 0, 0, 0, 8'h00, 8'hCC, 14'h0012, 0, 0, 1));
    // CPU writes, read-during-write, combined strobes
    q.push_back(mk(1, 14'h0020, 1, 0, 0, 0, 8'h00, 8'hCC, 14'h0020, 0, 0, 1));
    q.push_back(mk(1, 14'h0077, 0, 1, 0, 0, 8'h00, 8'h00, 14'h0020, 0, 0, 0));
    q.push_back(mk(1, 14'h005A, 0, 1, 0, 0, 8'h00, 8'h77, 14'h0020, 0, 0, 1));
    q.push_back(mk(1, 14'h0000, 0, 0, 0, 0, 8'h00, 8'h5A, 14'h0020, 0, 0, 1));
    q.push_back(mk(1, 14'h0030, 1, 1, 0, 0, 8'h00, 8'h5A, 14'h0030, 0, 0, 1));
    q.push_back(mk(1, 14'h0020, 1, 0, 0, 0, 8'h00, 8'h00, 14'h0020, 0, 0, 0));
    q.push_back(mk(1, 14'h0000, 0, 0, 0, 0, 8'h00, 8'h30, 14'h0020, 0, 0, 1));
    // reset mid-load after one data byte, then ld_valid without ld_start
    q.push_back(mk(1, 14'h0000, 0, 0, 1, 0, 8'h00, 8'h30, 14'h0020, 1, 1, 1));
    q.push_back(mk(1, 14'h0000, 0, 0, 0, 1, 8'h00, 8'h30, 14'h0020, 1, 1, 0));
    q.push_back(mk(1, 14'h0000, 0, 0, 0, 1, 8'h40, 8'h30, 14'h0020, 1, 1, 0));
    q.push_back(mk(1, 14'h0000, 0, 0, 0, 1, 8'h02, 8'h30, 14'h0020, 1, 1, 0));
    q.push_back(mk(1, 14'h0000, 0, 0, 0, 1, 8'h99, 8'h30, 14'h0020, 1, 1, 0));
    q.push_back(mk(0, 14'h0000, 0, 0, 0, 1, 8'h88, 8'h00, 14'h0000, 0, 0, 1));
    q.push_back(mk(1, 14'h0000, 0, 0, 0, 1, 8'h77, 8'h00, 14'h0000, 0, 0, 0));
    q.push_back(mk(1, 14'h0040, 1, 0, 0, 0, 8'h00, 8'h00, 14'h0040, 0, 0, 0));
    q.push_back(mk(1, 14'h0000, 0, 0, 0, 0, 8'h00, 8'h99, 14'h0040, 0, 0, 1));
    foreach (q[i]) step(q[i], $sformatf("vec%0d", i));
    // address wrap with ram_we pulsed while held (mar=0x40, mem[0x40]=0x99)
    begin
      logic [7:0] h[HDR_BYTES];
      h[0] = 8'h3F; h[1] = 8'hFF; h[2] = 8'h02;
      step(mk(1, 14'h0000, 0, 0, 1, 0, 8'h00, 8'h99, 14'h0040, 1, 1, 0), "wrap start");
      for (int i = 0; i < HDR_BYTES; i++)
        step(mk(1, 14'h0000, 0, 0, 0, 1, h[i], 8'h00, 14'h0040, 1, 1, 0), $sformatf("wrap hdr%0d", i));
    end
    step(mk(1, 14'h00EE, 0, 1, 0, 1, 8'h11, 8'h00, 14'h0040, 1, 1, 0), "wrap d0");
    step(mk(1, 14'h00EF, 0, 1, 0, 1, 8'h22, 8'h00, 14'h0040, 0, 0, 0), "wrap d1");
    step(mk(1, 14'h3FFF, 1, 0, 0, 0, 8'h00, 8'h00, 14'h3FFF, 0, 0, 0), "wrap rd0");
    step(mk(1, 14'h0000, 1, 0, 0, 0, 8'h00, 8'h11, 14'h0000, 0, 0, 1), "wrap rd1");
    step(mk(1, 14'h0040, 1, 0, 0, 0, 8'h00, 8'h22, 14'h0040, 0, 0, 1), "wrap rd2");
    step(mk(1, 14'h0000, 0, 0, 0, 0, 8'h00, 8'h99, 14'h0040, 0, 0, 1), "wrap gated");
    // length 0 means 256 bytes, loaded at 0x100
    step(mk(1, 14'h0000, 0, 0, 1, 0, 8'h00, 8'h99, 14'h0040, 1, 1, 1), "l256 start");
    step(mk(1, 14'h0000, 0, 0, 0, 1, 8'h01, 8'h99, 14'h0040, 1, 1, 0), "l256 hi");
    step(mk(1, 14'h0000, 0, 0, 0, 1, 8'h00, 8'h99, 14'h0040, 1, 1, 0), "l256 lo");
    step(mk(1, 14'h0000, 0, 0, 0, 1, 8'h00, 8'h99, 14'h0040, 1, 1, 0), "l256 len");
    for (int i = 0; i < 256; i++) begin
      logic [7:0] d;
      logic       busy;
      d = 8'(i) ^ 8'h5A;
      busy = i != 255;
      step(mk(1, 14'h0000, 0, 0, 0, 1, d, 8'h00, 14'h0040, busy, busy, 0), $sformatf("l256 d%0d", i));
    end
    step(mk(1, 14'h0100, 1, 0, 0, 1, 8'h33, 8'h00, 14'h0100, 0, 0, 0), "l256 rd0");
    step(mk(1, 14'h01FF, 1, 0, 0, 0, 8'h00, 8'h5A, 14'h01FF, 0, 0, 1), "l256 rd1");
    step(mk(1, 14'h0000, 0, 0, 0, 0, 8'h00, 8'hA5, 14'h01FF, 0, 0, 1), "l256 rd2");
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
